div_iter_unit: RTL and testbench



---
 rtl/div_iter_unit_pkg.sv | 17 +
 rtl/div_step.sv | 23 ++
 rtl/div_iter_unit.sv | 135 +++++++++++++
 tb/tb_div_iter_unit.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_iter_unit_pkg.sv
// Shared state codes and handshake constants for the EX-stage divide unit.
// The encodings mirror the constants the EX stage already compares against.
package div_iter_unit_pkg;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_t;

    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;
    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring iteration: shift in a dividend bit, trial-subtract
// the divisor, and keep the difference only when it does not go negative.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] partial;

    // A non-negative trial difference is the same as partial >= divisor; the
    // kept difference is below the divisor, so WIDTH bits hold it exactly.
    always_comb begin
        partial = {rem_in, dvd_bit};
        q_bit   = (partial >= {1'b0, divisor});
        rem_out = q_bit ? (partial[WIDTH-1:0] - divisor) : partial[WIDTH-1:0];
    end

endmodule

// File: rtl/div_iter_unit.sv
// Multi-cycle DIV/DIVU unit: one quotient bit per clock on magnitudes, with
// signs stripped at capture and restored on the final iteration.
module div_iter_unit
    import div_iter_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    div_state_t state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [WIDTH-1:0]   dvd, dvd_nxt;
    logic [WIDTH-1:0]   rem, rem_nxt;
    logic [WIDTH-2:0]   quot, quot_nxt;
    logic [WIDTH-1:0]   divisor, divisor_nxt;
    logic               qneg, qneg_nxt;
    logic               rneg, rneg_nxt;
    logic [2*WIDTH-1:0] result_nxt;
    logic               ready_nxt;

    logic [WIDTH-1:0]   step_rem;
    logic               step_q;
    logic [WIDTH-1:0]   final_quot;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem),
        .dvd_bit (dvd[WIDTH-1]),
        .divisor (divisor),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    assign final_quot = {quot, step_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= DIV_FREE;
            cnt      <= '0;
            dvd      <= '0;
            rem      <= '0;
            quot     <= '0;
            divisor  <= '0;
            qneg     <= 1'b0;
            rneg     <= 1'b0;
            result_o <= '0;
            ready_o  <= DIV_RESULT_NOT_READY;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            dvd      <= dvd_nxt;
            rem      <= rem_nxt;
            quot     <= quot_nxt;
            divisor  <= divisor_nxt;
            qneg     <= qneg_nxt;
            rneg     <= rneg_nxt;
            result_o <= result_nxt;
            ready_o  <= ready_nxt;
        end
    end

    // Annul outranks iteration in ON; the divisor==0 check uses the raw
    // operand because its magnitude is zero in either mode.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        dvd_nxt     = dvd;
        rem_nxt     = rem;
        quot_nxt    = quot;
        divisor_nxt = divisor;
        qneg_nxt    = qneg;
        rneg_nxt    = rneg;
        result_nxt  = result_o;
        ready_nxt   = ready_o;

        case (state)
            DIV_FREE: begin
                ready_nxt = DIV_RESULT_NOT_READY;
                if (start_i == DIV_START && !annul_i) begin
                    dvd_nxt     = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
                    divisor_nxt = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
                    qneg_nxt    = signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                    rneg_nxt    = signed_div_i && opdata1_i[WIDTH-1];
                    cnt_nxt     = '0;
                    rem_nxt     = '0;
                    quot_nxt    = '0;
                    state_nxt   = (opdata2_i == '0) ? DIV_BY_ZERO : DIV_ON;
                end
            end
            DIV_BY_ZERO: begin
                result_nxt = '0;
                ready_nxt  = DIV_RESULT_READY;
                state_nxt  = DIV_END;
            end
            DIV_ON: begin
                if (annul_i) begin
                    result_nxt = '0;
                    ready_nxt  = DIV_RESULT_NOT_READY;
                    state_nxt  = DIV_FREE;
                end else begin
                    rem_nxt  = step_rem;
                    quot_nxt = final_quot[WIDTH-2:0];
                    dvd_nxt  = {dvd[WIDTH-2:0], 1'b0};
                    cnt_nxt  = cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        result_nxt = {rneg ? -step_rem : step_rem,
                                      qneg ? -final_quot : final_quot};
                        ready_nxt  = DIV_RESULT_READY;
                        state_nxt  = DIV_END;
                    end
                end
            end
            DIV_END: begin
                if (start_i == DIV_STOP) begin
                    result_nxt = '0;
                    ready_nxt  = DIV_RESULT_NOT_READY;
                    state_nxt  = DIV_FREE;
                end
            end
            default: state_nxt = DIV_FREE;
        endcase
    end

endmodule

// File: tb/tb_div_iter_unit.sv
// Randomized bench for div_iter_unit against a plain-arithmetic model of
// MIPS DIV/DIVU, including the handshake timing around ready.
module tb_div_iter_unit;

    logic        clk;
    logic        rst;
    logic        signed_div;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;

    int num_compared;
    int num_mismatched;

    div_iter_unit #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case a wait loop is ever left unbounded.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        num_compared++;
        if (observed !== expected) begin
            num_mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // HI = remainder, LO = quotient; truncating division on 64-bit values
    // covers the 0x80000000 / -1 overflow without special-casing it.
    function automatic logic [63:0] ref_divide(input logic sgn, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full handshake: capture, wait for ready, optionally hold start in END,
    // then drop start and check the clear.
    task automatic apply_stimulus(input string tag, input logic sgn, input logic [31:0] a,
                                  input logic [31:0] b, input int hold_cycles);
        logic [63:0] expected;
        int          latency;
        int          edges;
        expected   = ref_divide(sgn, a, b);
        latency    = (b == 32'd0) ? 1 : 32;
        signed_div = sgn;
        op1        = a;
        op2        = b;
        start      = 1'b1;
        annul      = 1'b0;
        tick();
        edges = 0;
        while (edges < 40 && ready !== 1'b1) begin
            op1        = $urandom;
            op2        = $urandom;
            signed_div = 1'($urandom_range(0, 1));
            start      = 1'($urandom_range(0, 1));
            tick();
            edges++;
        end
        check_output({tag, " latency"}, 64'(edges), 64'(latency));
        check_output({tag, " result"}, result, expected);
        start = 1'b1;
        for (int i = 0; i < hold_cycles; i++) begin
            tick();
            check_output({tag, " hold ready"}, 64'(ready), 64'd1);
            check_output({tag, " hold result"}, result, expected);
        end
        start = 1'b0;
        tick();
        check_output({tag, " clear"}, {63'd0, ready} | result, 64'd0);
    endtask

    // Counts how many of the next n edges show ready, expected to be none.
    task automatic expect_quiet(input string tag, input int n);
        int rises;
        rises = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (ready === 1'b1) rises++;
        end
        check_output(tag, 64'(rises), 64'd0);
    endtask

    initial begin
        logic [31:0] a, b;
        logic        sgn;
        int          kind;
        int          edges;

        num_compared   = 0;
        num_mismatched = 0;
        rst        = 1'b1;
        signed_div = 1'b0;
        op1        = '0;
        op2        = '0;
        start      = 1'b0;
        annul      = 1'b0;
        repeat (3) tick();
        check_output("reset ready", 64'(ready), 64'd0);
        check_output("reset result", result, 64'd0);
        rst = 1'b0;
        tick();

        apply_stimulus("u 7/2", 1'b0, 32'd7, 32'd2, 0);
        apply_stimulus("s -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 0);
        apply_stimulus("s 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 0);
        apply_stimulus("u 5/0", 1'b0, 32'd5, 32'd0, 0);
        apply_stimulus("s 5/0", 1'b1, 32'd5, 32'd0, 0);
        apply_stimulus("s overflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        apply_stimulus("u max/1", 1'b0, 32'hFFFF_FFFF, 32'd1, 0);
        apply_stimulus("u max/max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        apply_stimulus("hold 5", 1'b1, 32'hFFFF_FF9C, 32'd7, 5);

        // Annul at the tenth edge after capture; EX drops start with it.
        signed_div = 1'b0;
        op1   = 32'h64;
        op2   = 32'h3;
        start = 1'b1;
        tick();
        repeat (9) tick();
        annul = 1'b1;
        start = 1'b0;
        tick();
        annul = 1'b0;
        check_output("annul cleared", {63'd0, ready} | result, 64'd0);
        expect_quiet("annul no ready", 40);
        apply_stimulus("after annul 9/3", 1'b0, 32'd9, 32'd3, 0);

        // Annul held in FREE blocks capture even with start high.
        op1   = 32'd50;
        op2   = 32'd5;
        start = 1'b1;
        annul = 1'b1;
        repeat (3) tick();
        start = 1'b0;
        annul = 1'b0;
        expect_quiet("annul in free", 36);

        // Reset on the fifteenth edge of an in-flight divide.
        op1   = 32'd1000;
        op2   = 32'd7;
        start = 1'b1;
        tick();
        repeat (14) tick();
        rst = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        check_output("rst mid ready", 64'(ready), 64'd0);
        check_output("rst mid result", result, 64'd0);
        expect_quiet("rst mid quiet", 36);

        // Reset while the result is being held in END.
        op1   = 32'd1000;
        op2   = 32'd7;
        start = 1'b1;
        tick();
        edges = 0;
        while (edges < 40 && ready !== 1'b1) begin
            tick();
            edges++;
        end
        check_output("pre-rst result", result, ref_divide(1'b0, 32'd1000, 32'd7));
        rst = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        check_output("rst end cleared", {63'd0, ready} | result, 64'd0);
        tick();
        apply_stimulus("after rst 9/3", 1'b0, 32'd9, 32'd3, 0);

        for (int n = 0; n < 24; n++) begin
            kind = int'($urandom_range(0, 4));
            sgn  = 1'($urandom_range(0, 1));
            a    = $urandom;
            case (kind)
                0:       b = $urandom;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'd0;
                3:       begin b = $urandom | 32'h8000_0000; a = a >> 4; end
                default: b = -32'($urandom_range(1, 300));
            endcase
            apply_stimulus($sformatf("rand%0d", n), sgn, a, b, int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
        $finish;
    end

endmodule
